// File: rtl/design_switch_pkg.sv
// design_switch_pkg
//   Types and helpers shared by the design-switch controller and its
//   request debouncer.
//   - sw_state_e : break-before-make sequencer state encoding
//   - SEL_W_DEF  : default width of the design select
//   - cnt_width(): width that holds the largest of the cycle parameters
package design_switch_pkg;

  localparam int SEL_W_DEF = 3;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } sw_state_e;

  // Bits needed to hold any value 0..max(a,b,c) inclusive.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/design_switch_sel_debounce.sv
// sel_debounce
//   Two-flop synchroniser on the raw design-select request followed by a
//   stability filter. The candidate value is reported stable once the
//   synchronised request has matched it for DEBOUNCE_CYCLES consecutive
//   cycles.
//   Ports:
//     clk_i   - system clock
//     rst     - asynchronous active-high reset
//     sel_req - raw request, asynchronous to clk_i
//     cand    - current debounce candidate
//     stable  - cand has held for DEBOUNCE_CYCLES cycles
module sel_debounce
  import design_switch_pkg::*;
#(
  parameter int SEL_W           = SEL_W_DEF,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_req,
  output logic [SEL_W-1:0] cand,
  output logic             stable
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  // The bus is synchronised bit by bit, so bits may land on different
  // cycles; a skewed intermediate value only restarts the debounce count
  // and can never be reported stable.
  logic [SEL_W-1:0] sync1, sync2;
  logic [DB_W-1:0]  cnt;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= sel_req;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != DB_W'(DEBOUNCE_CYCLES)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable = (cnt == DB_W'(DEBOUNCE_CYCLES));

endmodule

// File: rtl/design_switch_ctrl.sv
// design_switch_ctrl
//   Break-before-make sequencer for the design select that drives the
//   shared pad mux. A debounced change of the requested design puts every
//   design in reset and gates all pad output enables (DRAIN), swaps the
//   active select (SWITCH), holds reset with the new select applied
//   (SETTLE), then releases the new design's reset (RUN).
//   Ports:
//     clk_i             - system clock
//     rst               - asynchronous active-high reset
//     design_sel_req    - raw requested design, asynchronous
//     rst_override_n    - global design-reset override, active low
//     design_sel_active - select driving the pad mux
//     design_rst_n      - per-slot active-low reset, at most one bit high
//     io_gate           - forces all pad output enables off when 1
//     busy              - switch sequence in progress
//     switch_count      - completed switches, wraps at 256
module design_switch_ctrl
  import design_switch_pkg::*;
#(
  parameter int SEL_W           = SEL_W_DEF,
  parameter int NUM_DESIGNS     = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DRAIN_CYCLES    = 4,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       design_sel_req,
  input  logic                   rst_override_n,
  output logic [SEL_W-1:0]       design_sel_active,
  output logic [NUM_DESIGNS-1:0] design_rst_n,
  output logic                   io_gate,
  output logic                   busy,
  output logic [7:0]             switch_count
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, DRAIN_CYCLES, SETTLE_CYCLES);

  if (NUM_DESIGNS != (2 ** SEL_W)) begin : g_bad_num_designs
    $error("design_switch_ctrl: NUM_DESIGNS must equal 2**SEL_W");
  end
  if (DEBOUNCE_CYCLES < 1 || DRAIN_CYCLES < 1 || SETTLE_CYCLES < 1) begin : g_bad_cycles
    $error("design_switch_ctrl: cycle parameters must be >= 1");
  end

  // ---------------------------------------------------------------------
  // Request synchroniser / debouncer
  // ---------------------------------------------------------------------
  logic [SEL_W-1:0] cand;
  logic             stable;

  sel_debounce #(
    .SEL_W           (SEL_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sel_debounce (
    .clk_i   (clk_i),
    .rst     (rst),
    .sel_req (design_sel_req),
    .cand    (cand),
    .stable  (stable)
  );

  // ---------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------
  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;
  logic [SEL_W-1:0] target_q, target_d;
  logic [SEL_W-1:0] active_q, active_d;
  logic [7:0]       count_q, count_d;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      ph_cnt_q <= '0;
      target_q <= '0;
      active_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      ph_cnt_q <= ph_cnt_d;
      target_q <= target_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ph_cnt_d = ph_cnt_q;
    target_d = target_q;
    active_d = active_q;
    count_d  = count_q;
    case (state_q)
      RUN: begin
        // The target is latched here so request changes during the
        // sequence cannot alter the switch already under way; they are
        // picked up from cand once the sequence is back in RUN.
        if (stable && (cand != active_q)) begin
          target_d = cand;
          ph_cnt_d = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        if (ph_cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
          ph_cnt_d = '0;
          state_d  = SWITCH;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      SWITCH: begin
        active_d = target_q;
        ph_cnt_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (ph_cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          ph_cnt_d = '0;
          count_d  = count_q + 8'd1;
          state_d  = RUN;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode (Moore, from registered state)
  // ---------------------------------------------------------------------
  logic [NUM_DESIGNS-1:0] sel_onehot;

  assign sel_onehot = {{(NUM_DESIGNS-1){1'b0}}, 1'b1} << active_q;

  assign busy              = (state_q != RUN);
  assign io_gate           = busy;
  assign design_sel_active = active_q;
  assign switch_count      = count_q;

  // rst is folded in so every design is held in reset while the block
  // itself is in reset, not only once the sequencer has left RUN.
  assign design_rst_n = ((state_q == RUN) && rst_override_n && !rst) ? sel_onehot
                                                                     : '0;

endmodule

// File: tb/tb_design_switch_ctrl.sv
module tb_design_switch_ctrl;

  localparam int SEL_W       = 3;
  localparam int NUM_DESIGNS = 8;
  localparam int DEB         = 4;
  localparam int DRN         = 2;
  localparam int STL         = 3;
  localparam int GATE_LEN    = DRN + 1 + STL;

  logic                   clk_i = 1'b0;
  logic                   rst = 1'b1;
  logic [SEL_W-1:0]       design_sel_req = '0;
  logic                   rst_override_n = 1'b1;
  logic [SEL_W-1:0]       design_sel_active;
  logic [NUM_DESIGNS-1:0] design_rst_n;
  logic                   io_gate;
  logic                   busy;
  logic [7:0]             switch_count;

  design_switch_ctrl #(
    .SEL_W           (SEL_W),
    .NUM_DESIGNS     (NUM_DESIGNS),
    .DEBOUNCE_CYCLES (DEB),
    .DRAIN_CYCLES    (DRN),
    .SETTLE_CYCLES   (STL)
  ) dut (
    .clk_i             (clk_i),
    .rst               (rst),
    .design_sel_req    (design_sel_req),
    .rst_override_n    (rst_override_n),
    .design_sel_active (design_sel_active),
    .design_rst_n      (design_rst_n),
    .io_gate           (io_gate),
    .busy              (busy),
    .switch_count      (switch_count)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [SEL_W-1:0] active;
    logic [7:0]       count;
  } exp_t;

  typedef struct {
    logic [SEL_W-1:0] req;
    int               hold;
    bit               sw;
    logic [SEL_W-1:0] exp_active;
    logic [7:0]       exp_count;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_DESIGNS-1:0] oh(input logic [SEL_W-1:0] s);
    logic [NUM_DESIGNS-1:0] r;
    r = 1;
    return r << s;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every completed gate window must match the
  // oldest expected switch, both in result and in window length.
  logic prev_gate = 1'b0;
  int   gate_len  = 0;

  always @(negedge clk_i) begin
    exp_t e;
    if (rst) begin
      prev_gate = 1'b0;
      gate_len  = 0;
    end else begin
      if (io_gate) begin
        gate_len++;
      end else if (prev_gate) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_switch: got gate window of %0d cycles, active=%0d, expected none",
                   gate_len, design_sel_active);
        end else begin
          e = sb_q.pop_front();
          chk("sb_active", 32'(design_sel_active), 32'(e.active));
          chk("sb_count", 32'(switch_count), 32'(e.count));
          chk("sb_gate_len", 32'(gate_len), 32'(GATE_LEN));
          chk("sb_rst_n", 32'(design_rst_n), 32'(oh(e.active)));
        end
        gate_len = 0;
      end
      prev_gate = io_gate;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_gate;

    // Table: glitch, same-as-active, three real switches (incl. slot 0),
    // then an idle hold with the request equal to active.
    vecs[0] = '{req: 3'd1, hold: 3,  sw: 1'b0, exp_active: 3'd4, exp_count: 8'd1};
    vecs[1] = '{req: 3'd4, hold: 12, sw: 1'b0, exp_active: 3'd4, exp_count: 8'd1};
    vecs[2] = '{req: 3'd2, hold: 16, sw: 1'b1, exp_active: 3'd2, exp_count: 8'd2};
    vecs[3] = '{req: 3'd0, hold: 16, sw: 1'b1, exp_active: 3'd0, exp_count: 8'd3};
    vecs[4] = '{req: 3'd5, hold: 16, sw: 1'b1, exp_active: 3'd5, exp_count: 8'd4};
    vecs[5] = '{req: 3'd5, hold: 8,  sw: 1'b0, exp_active: 3'd5, exp_count: 8'd4};

    // ---- reset ----
    #2;
    chk("rst_gate", 32'(io_gate), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rst_n", 32'(design_rst_n), 0);
    chk("rst_active", 32'(design_sel_active), 0);
    chk("rst_count", 32'(switch_count), 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (DEB + 4) tick();
    chk("idle_active", 32'(design_sel_active), 0);
    chk("idle_gate", 32'(io_gate), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rst_n", 32'(design_rst_n), 32'h01);
    chk("idle_count", 32'(switch_count), 0);

    // ---- clean switch 0 -> 4, cycle-exact ----
    design_sel_req = 3'd4;
    sb_q.push_back('{active: 3'd4, count: 8'd1});
    tick();  // edge k samples the new request
    for (int i = 1; i <= 15; i++) begin
      tick();
      exp_gate = (i >= 7 && i <= 12);
      chk("clean_gate", 32'(io_gate), 32'(exp_gate));
      chk("clean_busy", 32'(busy), 32'(exp_gate));
      chk("clean_active", 32'(design_sel_active), (i >= 10) ? 4 : 0);
      chk("clean_rst_n", 32'(design_rst_n),
          exp_gate ? 0 : ((i >= 13) ? 32'h10 : 32'h01));
      chk("clean_count", 32'(switch_count), (i >= 13) ? 1 : 0);
    end

    // ---- table-driven vectors ----
    for (int v = 0; v < 6; v++) begin
      design_sel_req = vecs[v].req;
      if (vecs[v].sw)
        sb_q.push_back('{active: vecs[v].exp_active, count: vecs[v].exp_count});
      repeat (vecs[v].hold) tick();
      chk("vec_active", 32'(design_sel_active), 32'(vecs[v].exp_active));
      chk("vec_count", 32'(switch_count), 32'(vecs[v].exp_count));
      chk("vec_gate", 32'(io_gate), 0);
      chk("vec_rst_n", 32'(design_rst_n), 32'(oh(vecs[v].exp_active)));
    end

    // ---- request changes mid-sequence: 5 -> 2, then 2 -> 3 ----
    design_sel_req = 3'd2;
    sb_q.push_back('{active: 3'd2, count: 8'd5});
    tick();
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 6) begin
        design_sel_req = 3'd3;
        sb_q.push_back('{active: 3'd3, count: 8'd6});
      end
      exp_gate = (i >= 7 && i <= 12) || (i >= 14 && i <= 19);
      chk("mid_gate", 32'(io_gate), 32'(exp_gate));
      if (i == 13) chk("mid_active_first", 32'(design_sel_active), 2);
      if (i == 13) chk("mid_rst_n_run", 32'(design_rst_n), 32'h04);
    end
    chk("mid_active_final", 32'(design_sel_active), 3);
    chk("mid_count", 32'(switch_count), 6);

    // ---- override in RUN ----
    rst_override_n = 1'b0;
    #1;
    chk("ovr_rst_n", 32'(design_rst_n), 0);
    chk("ovr_gate", 32'(io_gate), 0);
    repeat (2) tick();
    chk("ovr_busy", 32'(busy), 0);
    chk("ovr_active", 32'(design_sel_active), 3);
    chk("ovr_rst_n_hold", 32'(design_rst_n), 0);
    rst_override_n = 1'b1;
    #1;
    chk("ovr_restore", 32'(design_rst_n), 32'h08);

    // ---- async reset mid-DRAIN ----
    design_sel_req = 3'd6;
    sb_q.push_back('{active: 3'd6, count: 8'd7});
    for (int i = 0; i < 30 && !io_gate; i++) tick();
    chk("ar_gate_rise", 32'(io_gate), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_gate", 32'(io_gate), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_rst_n", 32'(design_rst_n), 0);
    chk("ar_active", 32'(design_sel_active), 0);
    chk("ar_count", 32'(switch_count), 0);
    sb_q.delete();
    design_sel_req = 3'd0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (DEB + 6) tick();
    chk("ar_post_active", 32'(design_sel_active), 0);
    chk("ar_post_count", 32'(switch_count), 0);
    chk("ar_post_gate", 32'(io_gate), 0);
    chk("ar_post_rst_n", 32'(design_rst_n), 32'h01);

    repeat (3) tick();
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
